adder_arbiter: RTL and testbench
================================

# adder_arbiter

Time-shares one instance of the team's 16-bit ripple adder, `adder_16`, between three requesters using round-robin arbitration. In the LC-3 datapath the requesters are 0 = PC+1, 1 = PC+offset and 2 = BaseR+offset. Accepted operations pass through a two-stage valid/ready pipeline: an operand register, then a result register. Results return on one shared response port, tagged with the requester ID.

## Interface
Parameters:
- none; width is fixed at 16 and requester count at 3.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous; discards all in-flight operations.
- `req_valid`  in  3  bit i = requester i presents an operation.
- `req_a0`, `req_b0`  in  16 each  requester 0 operands.
- `req_a1`, `req_b1`  in  16 each  requester 1 operands.
- `req_a2`, `req_b2`  in  16 each  requester 2 operands.
- `req_ready`  out  3  one-hot or zero; bit i = requester i accepted this cycle.
- `rsp_valid`  out  1  the result register holds a valid result.
- `rsp_id`  out  2  requester ID of the result (0..2).
- `rsp_sum`  out  16  (a + b) mod 2^16.
- `rsp_ready`  in  1  the consumer accepts the result.

## Operation
Handshake rules:
- A request transfers on a cycle where `req_valid[i] & req_ready[i]`.
- A requester holds its valid and operands stable until that transfer. `req_valid` must not depend on `req_ready`.
- A response transfers on a cycle where `rsp_valid & rsp_ready`.

State:
- S1 (operand register): `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
- S2 (result register): `rsp_valid`, `rsp_sum`, `rsp_id`.
- `last`: 2-bit round-robin pointer holding the most recent granted ID, range 0..2.

Pipeline movement:
- `adder_16` is driven by `s1_a` and `s1_b`. It computes combinationally with carry-in 0, and carry-out is dropped.
- `s2_free = !rsp_valid | rsp_ready`.
- `s1_free = !s1_valid | s2_free`.
- S1 moves into S2 when `s1_valid & s2_free`, capturing the adder output and `s1_id`.

Arbitration:
- Grants are possible only when `s1_free` and `!flush`.
- Priority order is last+1, last+2, last (all mod 3). The first requester in that order with `req_valid` set receives `req_ready`.
- `req_ready` is combinational from `req_valid`, `last`, pipeline state and `flush`. At most one bit is set.
- On a grant, S1 loads that requester's operands and ID, and `last` becomes the granted ID.
- `last` does not change on cycles without a grant.

Flush:
- Clears `s1_valid` and `rsp_valid`. No grant occurs that cycle.
- `last` is unchanged.
- A response presented in the flush cycle is not considered transferred, even if `rsp_ready` is high.

Reset:
- Clears `s1_valid` and `rsp_valid`, and sets `last` = 2 so requester 0 has highest priority first.
- Data registers reset to 0, so `rsp_sum` = 0 and `rsp_id` = 0.
- `rst` overrides `flush` and all handshakes.

## Timing
- Reset values: `rsp_valid` = 0, `rsp_sum` = 0, `rsp_id` = 0. `req_ready` = 0 while `rst` is high.
- Latency: a request accepted at edge N produces `rsp_valid` = 1 after edge N+1.
- Throughput: one operation per cycle while `rsp_ready` stays high.
- Backpressure, with `rsp_ready` low:
  - S2 holds its result.
  - S1 can take one more request, then holds.
  - `req_ready` drops to 0 once both stages are full.
  - When `rsp_ready` rises, S2 and S1 both advance in that same cycle, and a new grant is issued that same cycle.
- At most two operations are in flight.
- Results return in acceptance order.
- Overflow wraps, e.g. 0xFFFF + 0x0001 = 0x0000.
- When a requester deasserts valid, the rotation skips it. Fairness means no requester holding valid waits more than 2 grants.

## Test plan
- Reset, then only requester 0 valid with a0 = 0x3000, b0 = 0x0001:
  - `req_ready` = 001 in the first cycle.
  - `rsp_valid`, `rsp_id` = 0, `rsp_sum` = 0x3001 one cycle after acceptance.
  - All outputs read 0 during reset.
- All three valid continuously, `rsp_ready` = 1:
  - Grant order 0,1,2,0,1,2, one per cycle.
  - `rsp_id` follows the same sequence, lagging one cycle.
  - Sums match each requester's operand pair.
- Wrap: a1 = 0xFFFF, b1 = 0x0001 -> `rsp_sum` = 0x0000. Separately, 0x8000 + 0x8000 -> 0x0000.
- Backpressure, `rsp_ready` = 0 with two requests accepted:
  - `req_ready` = 000 from the third cycle on.
  - `rsp_sum` holds the first result.
  - Raise `rsp_ready`: results appear in acceptance order with no loss or duplication, and a grant occurs in the same cycle.
- Flush with S1 and S2 both full:
  - The next cycle has `rsp_valid` = 0.
  - No result for the flushed operations ever appears.
  - The next grant continues from `last` + 1.
- Reset asserted mid-stream with requests pending:
  - After release, `rsp_valid` = 0 and no stale result is emitted.
  - The first grant goes to the lowest-numbered valid requester in order 0,1,2.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: three operand requesters in, one tagged
// result out. The arbiter takes the slave side; requesters and consumer take the master side.
interface adder_arbiter_if;
  logic [2:0]  req_valid;
  logic [15:0] req_a0;
  logic [15:0] req_b0;
  logic [15:0] req_a1;
  logic [15:0] req_b1;
  logic [15:0] req_a2;
  logic [15:0] req_b2;
  logic [2:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_ready;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_a2, req_b2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_a2, req_b2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit ripple adder among three requesters
// (PC+1, PC+offset, BaseR+offset). Two-stage pipeline: operand register (S1),
// then result register (S2) which drives the tagged response port.
module adder_arbiter (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  adder_arbiter_if.slave bus
);

  logic        s1_valid_q;
  logic [15:0] s1_a_q;
  logic [15:0] s1_b_q;
  logic [1:0]  s1_id_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_sum_q;
  logic [1:0]  rsp_id_q;
  logic [1:0]  last_q;

  logic        s2_free;
  logic        s1_free;
  logic [2:0]  grant;
  logic [1:0]  grant_id;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] sum;
  logic        carry;

  assign s2_free = !rsp_valid_q || bus.rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // Ripple-carry add of the S1 operands; carry-in 0, carry-out discarded (mod 2^16).
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = s1_a_q[i] ^ s1_b_q[i] ^ carry;
      carry  = (s1_a_q[i] & s1_b_q[i]) | (carry & (s1_a_q[i] ^ s1_b_q[i]));
    end
  end

  // Round-robin grant: search starts at last+1 and wraps back to last.
  always_comb begin
    grant = 3'b000;
    if (!rst && s1_free && !flush) begin
      case (last_q)
        2'd0: begin
          if      (bus.req_valid[1]) grant = 3'b010;
          else if (bus.req_valid[2]) grant = 3'b100;
          else if (bus.req_valid[0]) grant = 3'b001;
        end
        2'd1: begin
          if      (bus.req_valid[2]) grant = 3'b100;
          else if (bus.req_valid[0]) grant = 3'b001;
          else if (bus.req_valid[1]) grant = 3'b010;
        end
        default: begin
          if      (bus.req_valid[0]) grant = 3'b001;
          else if (bus.req_valid[1]) grant = 3'b010;
          else if (bus.req_valid[2]) grant = 3'b100;
        end
      endcase
    end
  end

  // Encode the one-hot grant and select the granted requester's operands.
  always_comb begin
    grant_id = 2'd0;
    op_a     = bus.req_a0;
    op_b     = bus.req_b0;
    if (grant[1]) begin
      grant_id = 2'd1;
      op_a     = bus.req_a1;
      op_b     = bus.req_b1;
    end else if (grant[2]) begin
      grant_id = 2'd2;
      op_a     = bus.req_a2;
      op_b     = bus.req_b2;
    end
  end

  // Pipeline state: reset beats flush; flush empties both stages and blocks grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= 2'd0;
      last_q      <= 2'd2;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (s2_free) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_sum_q <= sum;
          rsp_id_q  <= s1_id_q;
        end
      end
      // When S1 is free its old content (if any) has just moved to S2.
      if (s1_free) begin
        s1_valid_q <= |grant;
        if (|grant) begin
          s1_a_q  <= op_a;
          s1_b_q  <= op_b;
          s1_id_q <= grant_id;
          last_q  <= grant_id;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset values, latency, round-robin order,
// wrap-around sums, backpressure, flush and mid-stream reset.
module tb_adder_arbiter;

  logic clk;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  adder_arbiter_if bus_if ();

  adder_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, 16'(bus_if.req_ready), 16'(exp));
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [15:0] s);
    chk({tag, "_valid"}, 16'(bus_if.rsp_valid), 16'd1);
    chk({tag, "_id"}, 16'(bus_if.rsp_id), 16'(id));
    chk({tag, "_sum"}, bus_if.rsp_sum, s);
  endtask

  initial begin
    logic [1:0]  gseq [6];
    logic [15:0] rr_sum [3];
    logic [2:0]  oh;
    gseq   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_sum = '{16'h0015, 16'h2345, 16'h1000};

    // Reset with requester 0 already presenting 0x3000 + 0x0001.
    rst              = 1'b1;
    flush            = 1'b0;
    bus_if.req_valid = 3'b001;
    bus_if.req_a0    = 16'h3000;
    bus_if.req_b0    = 16'h0001;
    bus_if.req_a1    = 16'h0000;
    bus_if.req_b1    = 16'h0000;
    bus_if.req_a2    = 16'h0000;
    bus_if.req_b2    = 16'h0000;
    bus_if.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_rsp_valid", 16'(bus_if.rsp_valid), 16'd0);
    chk("rst_rsp_id", 16'(bus_if.rsp_id), 16'd0);
    chk("rst_rsp_sum", bus_if.rsp_sum, 16'h0000);
    chk_rdy("rst_req_ready", 3'b000);

    // Single request: accepted first cycle, result one edge later.
    rst = 1'b0;
    chk_rdy("first_ready", 3'b001);
    tick();
    bus_if.req_valid = 3'b000;
    chk("lat_not_yet", 16'(bus_if.rsp_valid), 16'd0);
    tick();
    chk_rsp("first_rsp", 2'd0, 16'h3001);
    tick();
    chk("first_drain", 16'(bus_if.rsp_valid), 16'd0);

    // Round-robin with all three valid, fresh reset so requester 0 leads.
    rst = 1'b1;
    tick();
    rst              = 1'b0;
    bus_if.req_a0    = 16'h0010;
    bus_if.req_b0    = 16'h0005;
    bus_if.req_a1    = 16'h1234;
    bus_if.req_b1    = 16'h1111;
    bus_if.req_a2    = 16'h0F0F;
    bus_if.req_b2    = 16'h00F1;
    bus_if.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      oh = 3'b001 << gseq[k];
      chk_rdy("rr_ready", oh);
      tick();
      if (k > 0) chk_rsp("rr_rsp", gseq[k-1], rr_sum[gseq[k-1]]);
    end
    bus_if.req_valid = 3'b000;
    tick();
    chk_rsp("rr_last", 2'd2, 16'h1000);

    // Wrap-around sums on requesters 1 and 2 (last = 2 here).
    bus_if.req_a1    = 16'hFFFF;
    bus_if.req_b1    = 16'h0001;
    bus_if.req_a2    = 16'h8000;
    bus_if.req_b2    = 16'h8000;
    bus_if.req_valid = 3'b010;
    chk_rdy("wrap1_ready", 3'b010);
    tick();
    bus_if.req_valid = 3'b100;
    chk_rdy("wrap2_ready", 3'b100);
    tick();
    bus_if.req_valid = 3'b000;
    chk_rsp("wrap1_rsp", 2'd1, 16'h0000);
    tick();
    chk_rsp("wrap2_rsp", 2'd2, 16'h0000);
    tick();
    chk("wrap_drain", 16'(bus_if.rsp_valid), 16'd0);

    // Backpressure: two accepted, then stall, then release with same-cycle grant.
    bus_if.req_a0    = 16'h0100;
    bus_if.req_b0    = 16'h0001;
    bus_if.req_a1    = 16'h0200;
    bus_if.req_b1    = 16'h0002;
    bus_if.req_a2    = 16'h0300;
    bus_if.req_b2    = 16'h0003;
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 3'b111;
    chk_rdy("bp_ready0", 3'b001);
    tick();
    bus_if.req_valid = 3'b110;
    chk_rdy("bp_ready1", 3'b010);
    tick();
    bus_if.req_valid = 3'b100;
    chk_rsp("bp_hold0", 2'd0, 16'h0101);
    chk_rdy("bp_full_ready", 3'b000);
    tick();
    chk_rsp("bp_hold1", 2'd0, 16'h0101);
    chk_rdy("bp_still_full", 3'b000);
    bus_if.rsp_ready = 1'b1;
    chk_rdy("bp_release_grant", 3'b100);
    tick();
    bus_if.req_valid = 3'b000;
    chk_rsp("bp_rsp1", 2'd1, 16'h0202);
    tick();
    chk_rsp("bp_rsp2", 2'd2, 16'h0303);
    tick();
    chk("bp_drain", 16'(bus_if.rsp_valid), 16'd0);

    // Flush with both stages full (last = 2 before, 1 after the two grants).
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 3'b001;
    tick();
    bus_if.req_valid = 3'b010;
    chk_rdy("fl_ready1", 3'b010);
    tick();
    bus_if.req_valid = 3'b100;
    chk("fl_full", 16'(bus_if.rsp_valid), 16'd1);
    flush            = 1'b1;
    bus_if.rsp_ready = 1'b1;
    chk_rdy("fl_no_grant", 3'b000);
    tick();
    flush = 1'b0;
    chk("fl_rsp_cleared", 16'(bus_if.rsp_valid), 16'd0);
    bus_if.req_valid = 3'b111;
    chk_rdy("fl_next_grant", 3'b100);
    tick();
    bus_if.req_valid = 3'b000;
    chk("fl_no_stale", 16'(bus_if.rsp_valid), 16'd0);
    tick();
    chk_rsp("fl_rsp", 2'd2, 16'h0303);
    tick();
    chk("fl_drain", 16'(bus_if.rsp_valid), 16'd0);

    // Reset mid-stream with requests pending and both stages full.
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 3'b111;
    tick();
    tick();
    rst = 1'b1;
    chk_rdy("mr_rst_ready", 3'b000);
    tick();
    rst = 1'b0;
    chk("mr_rsp_valid", 16'(bus_if.rsp_valid), 16'd0);
    chk("mr_rsp_sum", bus_if.rsp_sum, 16'h0000);
    bus_if.rsp_ready = 1'b1;
    chk_rdy("mr_first_grant", 3'b001);
    tick();
    bus_if.req_valid = 3'b000;
    chk("mr_no_stale", 16'(bus_if.rsp_valid), 16'd0);
    tick();
    chk_rsp("mr_rsp", 2'd0, 16'h0101);
    tick();
    chk("mr_drain", 16'(bus_if.rsp_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
